// File: rtl/ddr3_app_pkg.sv
// Shared definitions for the DDR3 application-interface responder:
// command encodings, FSM states and interface widths.
package ddr3_app_pkg;

  localparam int ADDR_W  = 27;
  localparam int DATA_W  = 128;
  localparam int BE_W    = DATA_W / 8;
  localparam int BURST_W = 6;

  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;

  typedef enum logic [2:0] {
    ST_CALIB    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_WRITE    = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_BURST = 3'd4
  } state_t;

endpackage

// File: rtl/ddr3_app_responder_bram.sv
// Single-port 128-bit word store with per-byte write enables and a
// one-cycle registered read, shaped to map onto Gowin BSRAM.
module app_bram_128
  import ddr3_app_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Byte-masked write port.
  // NOTE: the array has no reset; clearing it would prevent block-RAM mapping and contents must survive reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered read; the output only moves on a read so it holds between bursts.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ddr3_app_responder.sv
// Behavioural stand-in for a DDR3 controller user interface: models the
// calibration delay, write/read bursts with fixed read latency, and flags
// protocol misuse on a sticky error output.
module ddr3_app_responder
  import ddr3_app_pkg::*;
#(
  parameter int MEM_AW       = 10,
  parameter int CALIB_CYCLES = 64,
  parameter int RD_LAT       = 4   // must be at least 2: one cycle to issue, one for the RAM read
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               app_cmd_en,
  input  logic [2:0]         app_cmd,
  input  logic [ADDR_W-1:0]  app_addr,
  input  logic [BURST_W-1:0] app_burst_number,
  output logic               app_cmd_rdy,
  input  logic               app_wdata_en,
  input  logic [DATA_W-1:0]  app_wdata,
  input  logic [BE_W-1:0]    app_wdata_mask,
  input  logic               app_wdata_end,
  output logic               app_wdata_rdy,
  output logic [DATA_W-1:0]  app_rdata,
  output logic               app_rdata_valid,
  output logic               app_rdata_end,
  output logic               init_calib_complete,
  output logic               proto_err
);

  localparam int CAL_W = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CALIB_CYCLES - 1);
  localparam int RDW_W = $clog2(RD_LAT);
  localparam logic [RDW_W-1:0] RDW_LAST = RDW_W'(RD_LAT - 1);

  state_t              state;
  logic [CAL_W-1:0]    calib_cnt;
  logic [RDW_W-1:0]    wait_cnt;
  logic [MEM_AW-1:0]   base_q;
  logic [BURST_W-1:0]  last_q;
  logic [BURST_W-1:0]  beat_cnt;

  logic                cmd_acc;
  logic [MEM_AW-1:0]   cmd_word;
  logic                ram_en;
  logic                ram_we;
  logic [MEM_AW-1:0]   ram_addr;
  logic                unused_addr_bits;

  assign cmd_acc  = app_cmd_en && app_cmd_rdy;
  assign cmd_word = app_addr[MEM_AW+2:3];
  // Sub-word and above-memory address bits carry no meaning here.
  assign unused_addr_bits = ^{app_addr[ADDR_W-1:MEM_AW+3], app_addr[2:0]};

  // RAM port steering: the accept cycle writes through the live address,
  // later beats use the registered base plus the beat offset (wrapping).
  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    ram_addr = base_q + MEM_AW'(beat_cnt);
    ram_we   = 1'b0;
    ram_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        ram_addr = cmd_word;
        ram_we   = cmd_acc && (app_cmd == CMD_WRITE) && app_wdata_en;
      end
      ST_WRITE: begin
        ram_we = app_wdata_en;
      end
      ST_RD_WAIT: begin
        ram_addr = base_q;
        ram_en   = (wait_cnt == RDW_LAST);
      end
      ST_RD_BURST: begin
        ram_addr = base_q + MEM_AW'(beat_cnt + 6'd1);
        ram_en   = (beat_cnt != last_q);
      end
      default: ;
    endcase
    ram_en = ram_en | ram_we;
  end

  app_bram_128 #(.AW(MEM_AW)) u_bram (
    .clk   (clk),
    .rstn  (rstn),
    .en    (ram_en),
    .we    (ram_we),
    .be    (~app_wdata_mask),
    .addr  (ram_addr),
    .wdata (app_wdata),
    .rdata (app_rdata)
  );

  // Control FSM with all handshake and status outputs registered alongside the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state               <= ST_CALIB;
      calib_cnt           <= '0;
      wait_cnt            <= '0;
      base_q              <= '0;
      last_q              <= '0;
      beat_cnt            <= '0;
      init_calib_complete <= 1'b0;
      app_cmd_rdy         <= 1'b0;
      app_wdata_rdy       <= 1'b0;
      app_rdata_valid     <= 1'b0;
      app_rdata_end       <= 1'b0;
      proto_err           <= 1'b0;
    end else begin
      case (state)
        ST_CALIB: begin
          if (calib_cnt == CAL_LAST) begin
            state               <= ST_IDLE;
            init_calib_complete <= 1'b1;
            app_cmd_rdy         <= 1'b1;
            app_wdata_rdy       <= 1'b1;
          end else begin
            calib_cnt <= calib_cnt + 1'b1;
          end
        end

        ST_IDLE: begin
          if (cmd_acc) begin
            base_q   <= cmd_word;
            last_q   <= app_burst_number;
            beat_cnt <= '0;
            wait_cnt <= '0;
            case (app_cmd)
              CMD_WRITE: begin
                if (app_wdata_en) begin
                  if (app_wdata_end != (app_burst_number == '0)) proto_err <= 1'b1;
                  // A single-beat write completes on the accept edge itself.
                  if (app_burst_number != '0) begin
                    state       <= ST_WRITE;
                    app_cmd_rdy <= 1'b0;
                    beat_cnt    <= 6'd1;
                  end
                end else begin
                  state       <= ST_WRITE;
                  app_cmd_rdy <= 1'b0;
                end
              end
              CMD_READ: begin
                if (app_wdata_en) proto_err <= 1'b1;
                state         <= ST_RD_WAIT;
                app_cmd_rdy   <= 1'b0;
                app_wdata_rdy <= 1'b0;
              end
              default: begin
                proto_err <= 1'b1;
              end
            endcase
          end else if (app_wdata_en) begin
            proto_err <= 1'b1;
          end
        end

        ST_WRITE: begin
          if (app_wdata_en) begin
            if (app_wdata_end != (beat_cnt == last_q)) proto_err <= 1'b1;
            if (beat_cnt == last_q) begin
              state       <= ST_IDLE;
              app_cmd_rdy <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        ST_RD_WAIT: begin
          if (wait_cnt == RDW_LAST) begin
            state           <= ST_RD_BURST;
            app_rdata_valid <= 1'b1;
            app_rdata_end   <= (last_q == '0);
            beat_cnt        <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_RD_BURST: begin
          if (beat_cnt == last_q) begin
            state           <= ST_IDLE;
            app_rdata_valid <= 1'b0;
            app_rdata_end   <= 1'b0;
            app_cmd_rdy     <= 1'b1;
            app_wdata_rdy   <= 1'b1;
          end else begin
            beat_cnt      <= beat_cnt + 1'b1;
            app_rdata_end <= ((beat_cnt + 6'd1) == last_q);
          end
        end

        default: begin
          state <= ST_CALIB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Self-checking bench for ddr3_app_responder: directed scenarios plus
// randomized bursts checked against a word-array reference model.
module tb_ddr3_app_responder;
  import ddr3_app_pkg::*;

  localparam int MEM_AW       = 10;
  localparam int MEM_WORDS    = 1 << MEM_AW;
  localparam int CALIB_CYCLES = 64;
  localparam int RD_LAT       = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         app_cmd_en;
  logic [2:0]   app_cmd;
  logic [26:0]  app_addr;
  logic [5:0]   app_burst_number;
  logic         app_cmd_rdy;
  logic         app_wdata_en;
  logic [127:0] app_wdata;
  logic [15:0]  app_wdata_mask;
  logic         app_wdata_end;
  logic         app_wdata_rdy;
  logic [127:0] app_rdata;
  logic         app_rdata_valid;
  logic         app_rdata_end;
  logic         init_calib_complete;
  logic         proto_err;

  int checks = 0;
  int errors = 0;

  logic [127:0] mdl [MEM_WORDS];
  logic [127:0] wd [64];
  logic [15:0]  wm [64];

  always #5 clk = ~clk;

  ddr3_app_responder #(
    .MEM_AW(MEM_AW), .CALIB_CYCLES(CALIB_CYCLES), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .app_cmd_en(app_cmd_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_burst_number(app_burst_number), .app_cmd_rdy(app_cmd_rdy),
    .app_wdata_en(app_wdata_en), .app_wdata(app_wdata),
    .app_wdata_mask(app_wdata_mask), .app_wdata_end(app_wdata_end),
    .app_wdata_rdy(app_wdata_rdy), .app_rdata(app_rdata),
    .app_rdata_valid(app_rdata_valid), .app_rdata_end(app_rdata_end),
    .init_calib_complete(init_calib_complete), .proto_err(proto_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [26:0] addr);
    return int'(addr[12:3]);
  endfunction

  // Reference write: a mask bit of 1 leaves that byte untouched.
  task automatic model_write(input int idx, input logic [127:0] d, input logic [15:0] m);
    for (int b = 0; b < 16; b++)
      if (!m[b]) mdl[idx % MEM_WORDS][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic wait_cmd_rdy();
    int n = 0;
    while (!app_cmd_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_rdy_wait", app_cmd_rdy, 1'b1);
  endtask

  task automatic reset_and_calibrate();
    rstn = 1'b0;
    #1;
    check("rst_cmd_rdy", app_cmd_rdy, 1'b0);
    check("rst_wdata_rdy", app_wdata_rdy, 1'b0);
    check("rst_calib", init_calib_complete, 1'b0);
    check("rst_valid", app_rdata_valid, 1'b0);
    check("rst_end", app_rdata_end, 1'b0);
    check("rst_rdata", app_rdata, 128'h0);
    check("rst_proto", proto_err, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (CALIB_CYCLES - 1) @(negedge clk);
    check("calib_early", init_calib_complete, 1'b0);
    check("cmd_rdy_early", app_cmd_rdy, 1'b0);
    @(negedge clk);
    check("calib_done", init_calib_complete, 1'b1);
    check("cmd_rdy_idle", app_cmd_rdy, 1'b1);
    check("wdata_rdy_idle", app_wdata_rdy, 1'b1);
  endtask

  // Drives a write burst from wd/wm; end_beat selects where app_wdata_end is raised.
  task automatic write_burst(input logic [26:0] addr, input logic [5:0] bn,
                             input int end_beat, input bit gaps);
    int idx = word_of(addr);
    int k = 1;
    wait_cmd_rdy();
    app_cmd_en = 1'b1; app_cmd = CMD_WRITE; app_addr = addr; app_burst_number = bn;
    app_wdata_en = 1'b1; app_wdata = wd[0]; app_wdata_mask = wm[0];
    app_wdata_end = (end_beat == 0);
    model_write(idx, wd[0], wm[0]);
    @(negedge clk);
    app_cmd_en = 1'b0;
    if (bn != 0) check("wr_wdata_rdy", app_wdata_rdy, 1'b1);
    while (k <= int'(bn)) begin
      if (gaps && $urandom_range(3) == 0) begin
        app_wdata_en = 1'b0; app_wdata_end = 1'b0;
      end else begin
        app_wdata_en = 1'b1; app_wdata = wd[k]; app_wdata_mask = wm[k];
        app_wdata_end = (end_beat == k);
        model_write(idx + k, wd[k], wm[k]);
        k++;
      end
      @(negedge clk);
    end
    app_wdata_en = 1'b0; app_wdata_end = 1'b0;
    check("wr_back_idle", app_cmd_rdy, 1'b1);
  endtask

  // Issues a read and checks every cycle from accept to the following idle cycle.
  task automatic read_burst(input logic [26:0] addr, input logic [5:0] bn);
    int idx = word_of(addr);
    int len = int'(bn) + 1;
    wait_cmd_rdy();
    app_cmd_en = 1'b1; app_cmd = CMD_READ; app_addr = addr; app_burst_number = bn;
    @(negedge clk);
    app_cmd_en = 1'b0;
    for (int j = 0; j <= RD_LAT + len; j++) begin
      if (j >= RD_LAT && j < RD_LAT + len) begin
        check("rd_valid", app_rdata_valid, 1'b1);
        check("rd_end", app_rdata_end, (j == RD_LAT + len - 1));
        check("rd_data", app_rdata, mdl[(idx + j - RD_LAT) % MEM_WORDS]);
      end else begin
        check("rd_valid_idle", app_rdata_valid, 1'b0);
        check("rd_end_idle", app_rdata_end, 1'b0);
      end
      if (j < RD_LAT + len) @(negedge clk);
    end
    check("rd_back_idle", app_cmd_rdy, 1'b1);
  endtask

  initial begin
    rstn = 1'b0;
    app_cmd_en = 1'b0; app_cmd = '0; app_addr = '0; app_burst_number = '0;
    app_wdata_en = 1'b0; app_wdata = '0; app_wdata_mask = '0; app_wdata_end = 1'b0;
    @(negedge clk);
    reset_and_calibrate();

    // Fill the whole memory so every later read has a known expectation.
    for (int blk = 0; blk < MEM_WORDS / 64; blk++) begin
      for (int k = 0; k < 64; k++) begin
        wd[k] = {$urandom, $urandom, $urandom, $urandom};
        wm[k] = 16'h0;
      end
      write_burst(27'(blk * 64 * 8), 6'd63, 63, 1'b0);
    end

    // Four-beat write then read at the same address.
    for (int k = 0; k < 4; k++) begin
      wd[k] = 128'hCAFE_0000_0000_0000_0000_0000_0000_00A0 + 128'(k);
      wm[k] = 16'h0;
    end
    write_burst(27'h40, 6'd3, 3, 1'b0);
    read_burst(27'h40, 6'd3);

    // Masked write merges with the existing word.
    wd[0] = '1; wm[0] = 16'h0;
    write_burst(27'h100, 6'd0, 0, 1'b0);
    wd[0] = '0; wm[0] = 16'h00FF;
    write_burst(27'h100, 6'd0, 0, 1'b0);
    read_burst(27'h100, 6'd0);

    // Burst wraps from the last word to word 0; ignored address bits are set.
    wd[0] = {4{32'h1111_2222}}; wd[1] = {4{32'h3333_4444}}; wm[0] = '0; wm[1] = '0;
    write_burst(27'h400_0000 | 27'((MEM_WORDS - 1) * 8) | 27'd5, 6'd1, 1, 1'b0);
    read_burst(27'h0, 6'd0);
    read_burst(27'((MEM_WORDS - 1) * 8), 6'd1);
    check("proto_clean", proto_err, 1'b0);

    // Randomized traffic against the model.
    for (int it = 0; it < 30; it++) begin
      logic [26:0] a = 27'($urandom);
      logic [5:0]  bn = 6'($urandom_range(15));
      if ($urandom_range(1) == 0) begin
        for (int k = 0; k < 64; k++) begin
          wd[k] = {$urandom, $urandom, $urandom, $urandom};
          wm[k] = 16'($urandom);
        end
        write_burst(a, bn, int'(bn), 1'b1);
      end else begin
        read_burst(a, bn);
      end
    end
    check("proto_random", proto_err, 1'b0);

    // Misplaced end marker raises a sticky error.
    for (int k = 0; k < 4; k++) begin
      wd[k] = {4{$urandom}}; wm[k] = 16'h0;
    end
    write_burst(27'h200, 6'd3, 1, 1'b0);
    check("proto_end_mismatch", proto_err, 1'b1);
    read_burst(27'h200, 6'd3);
    check("proto_sticky", proto_err, 1'b1);

    // Reset during the second beat of an eight-beat read.
    wait_cmd_rdy();
    app_cmd_en = 1'b1; app_cmd = CMD_READ; app_addr = 27'h40; app_burst_number = 6'd7;
    @(negedge clk);
    app_cmd_en = 1'b0;
    repeat (RD_LAT + 1) @(negedge clk);
    check("abort_valid", app_rdata_valid, 1'b1);
    check("abort_data", app_rdata, mdl[9]);
    reset_and_calibrate();
    read_burst(27'h40, 6'd7);

    // Unknown command: accepted, flagged, no memory effect, stays idle.
    wait_cmd_rdy();
    app_cmd_en = 1'b1; app_cmd = 3'd5; app_addr = 27'h80; app_burst_number = 6'd2;
    app_wdata = '0; app_wdata_mask = '0;
    @(negedge clk);
    app_cmd_en = 1'b0;
    check("badcmd_proto", proto_err, 1'b1);
    check("badcmd_idle", app_cmd_rdy, 1'b1);
    check("badcmd_no_read", app_rdata_valid, 1'b0);
    read_burst(27'h80, 6'd2);

    // Stray write beat in idle is ignored and flagged.
    rstn = 1'b0;
    @(negedge clk);
    reset_and_calibrate();
    app_wdata_en = 1'b1; app_wdata = '0; app_wdata_mask = '0; app_addr = 27'h88;
    @(negedge clk);
    app_wdata_en = 1'b0;
    check("stray_proto", proto_err, 1'b1);
    read_burst(27'h88, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_app_responder.md
DDR3_APP_RESPONDER -- requirements
Module: ddr3_app_responder

Interface
REQ-001 SHALL have parameters: MEM_AW, default 10, word-address width giving 2^MEM_AW 128-bit words; CALIB_CYCLES, default 64, cycles from reset release to calibration done; RD_LAT, default 4, cycles from read-command accept to first read beat (minimum 2).
REQ-002 SHALL have ports: clk in 1, clock; rstn in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: app_cmd_en in 1, command strobe; app_cmd in 3, command with 0=write and 1=read; app_addr in 27, address in 16-bit units; app_burst_number in 6, beats minus one; app_cmd_rdy out 1, command ready.
REQ-004 SHALL have ports: app_wdata_en in 1, write beat strobe; app_wdata in 128, write data; app_wdata_mask in 16, byte mask with 1=byte not written; app_wdata_end in 1, last-beat marker; app_wdata_rdy out 1, write data ready.
REQ-005 SHALL have ports: app_rdata out 128, read data; app_rdata_valid out 1, read beat valid; app_rdata_end out 1, last read beat; init_calib_complete out 1, calibration done; proto_err out 1, sticky protocol-error flag.

Function
REQ-006 SHALL use FSM states CALIB, IDLE, WRITE, RD_WAIT and RD_BURST.
REQ-007 SHALL stay in CALIB for CALIB_CYCLES cycles after reset release, then set init_calib_complete to 1 and hold it at 1 until the next reset.
REQ-008 SHALL drive app_cmd_rdy to 1 only in IDLE.
REQ-009 SHALL drive app_wdata_rdy to 1 in IDLE and WRITE only.
REQ-010 SHALL accept a command on a cycle where app_cmd_en and app_cmd_rdy are both 1, registering app_addr, app_burst_number and app_cmd; burst length is app_burst_number+1, i.e. 1 to 64 beats.
REQ-011 SHALL compute the word index of beat k as (app_addr[MEM_AW+2:3] + k) mod 2^MEM_AW, so the index wraps at memory end; app_addr[2:0] and the bits above MEM_AW+2 SHALL be ignored.
REQ-012 On write-command accept, SHALL go to WRITE; an app_wdata_en beat in the same cycle SHALL count as beat 0.
REQ-013 In WRITE, SHALL store each beat where app_wdata_en and app_wdata_rdy are both 1, updating only bytes whose mask bit is 0.
REQ-014 SHALL return to IDLE on the cycle after the final beat is stored.
REQ-015 SHALL set proto_err when app_wdata_end disagrees with the final-beat position.
REQ-016 SHALL ignore app_wdata_en in IDLE when no write command is accepted in the same cycle, and SHALL set proto_err in that case.
REQ-017 On read-command accept, SHALL go to RD_WAIT; the first beat SHALL appear exactly RD_LAT cycles after the accept edge.
REQ-018 In RD_BURST, SHALL hold app_rdata_valid at 1 for burst-length consecutive cycles with no gaps and no backpressure.
REQ-019 SHALL assert app_rdata_end on the last read beat only, then return to IDLE.
REQ-020 SHALL clear app_rdata_valid and app_rdata_end outside RD_BURST; app_rdata SHALL hold its last value.
REQ-021 SHALL accept any app_cmd value other than 0 or 1 with no memory effect, set proto_err, and remain in IDLE.
REQ-022 SHALL ignore app_cmd_en outside IDLE.
REQ-023 SHALL let a new command be accepted on the first IDLE cycle after a burst, giving no more than 1 idle cycle between bursts.

Reset
REQ-024 On rstn low, SHALL enter CALIB and clear the calibration counter, init_calib_complete, app_cmd_rdy, app_wdata_rdy, app_rdata, app_rdata_valid, app_rdata_end and proto_err.
REQ-025 SHALL abandon any burst in progress on reset; a partial write SHALL keep the beats already stored.
REQ-026 SHALL NOT reset memory contents.

Structure
REQ-027 SHALL take the command encodings (write=3'd0, read=3'd1) from a shared package ddr3_app_pkg, which also holds the FSM state constants; the bridge SHALL use the same package.
REQ-028 SHALL place storage in one sub-module, app_bram_128: single-port, 1-cycle registered read, 16 byte-enables, inferable as Gowin BSRAM.

Verification
REQ-029 Reset release with CALIB_CYCLES=64 -> init_calib_complete rises on cycle 64; app_cmd_rdy=0 before then and 1 after.
REQ-030 Write addr 0x40, burst_number 3, data 0x...A0 to 0x...A3, mask 0; then read addr 0x40, burst_number 3 -> valid exactly RD_LAT=4 cycles after accept, then 4 consecutive beats A0..A3, rdata_end on beat 4.
REQ-031 Write word 0xFFFF...FF, then write 0x0 with mask 0x00FF, then read -> upper 8 bytes 0x00, lower 8 bytes 0xFF.
REQ-032 MEM_AW=10, write addr word 1023, burst_number 1 -> second beat lands at word 0; reading word 0 returns it.
REQ-033 Write burst of 4 beats with app_wdata_end on beat 2 -> proto_err=1 and sticky; app_cmd=3'd5 -> proto_err=1, no state change.
REQ-034 rstn pulse during beat 2 of an 8-beat read -> outputs zero within the reset cycle, CALIB is re-entered, and data written earlier still reads back after recalibration.
